alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, fully registered successor to the 8-bit four-function ALU.
- Holds one adder/subtractor, one serial shift register, one loadable up/down counter and one four-way logic unit.
- A 2-bit mode select `s` picks the function; a 2-bit sub-op `op` refines it.
- Result, carry and zero flag are registered, so the block can drop straight into a clocked datapath.

Parameters:
- WIDTH, 8, data width of a, b, f and of the internal shift and counter registers (WIDTH >= 2).

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  adder operand A; counter load value; a[0] is the shift serial input; logic operand A
- b  in  WIDTH  adder operand B; logic operand B
- L  in  1  adder carry/borrow-in; counter load strobe
- En  in  1  counter enable and shift-register enable
- s  in  2  mode: 00 ADD, 01 SHIFT, 10 COUNT, 11 LOGIC
- op  in  2  sub-operation within the mode (see Behaviour)
- f  out  WIDTH  registered result
- cout  out  1  registered carry / no-borrow (ADD) or wrap pulse (COUNT); 0 in other modes
- zero  out  1  registered, 1 when f == 0

Behaviour:
- **Timing and reset**
  - All outputs and internal registers update only on the rising edge of clock. Latency is 1 cycle from inputs to f/cout/zero.
  - When reset=1 at an edge: shift register sr=0, counter cnt=0, f=0, cout=0, zero=1. Reset overrides every other input.
  - Reset asserted mid-operation clears state at that edge. There is no partial result.
- **Register ownership**
  - sr and cnt hold their values whenever their mode is not selected. Only the selected unit's state may change.
  - f is loaded every cycle with the selected unit's result. zero = (next f == 0).
- **ADD (s=00)**
  - op[0]=0: {cout,f} <= a + b + L, computed at WIDTH+1 bits.
  - op[0]=1: subtract. {cout,f} <= a + ~b + ~L, i.e. a - b - L. cout=1 means no borrow.
  - op[1] is reserved and ignored.
- **SHIFT (s=01)**, acts only when En=1; with En=0, sr holds and f <= sr.
  - op=00, shift left: sr <= {sr[WIDTH-2:0], a[0]}.
  - op=01, shift right: sr <= {a[0], sr[WIDTH-1:1]}.
  - op=10, rotate left: a[0] is ignored.
  - op=11, rotate right: a[0] is ignored.
  - f <= new sr value. cout <= 0.
- **COUNT (s=10)**
  - Priority: L=1 loads cnt <= a, regardless of En. Otherwise En=1 counts. Otherwise cnt holds.
  - op[0]=0 counts up, op[0]=1 counts down. op[1] is reserved.
  - Modulo 2^WIDTH wrap: up from all-ones gives 0; down from 0 gives all-ones.
  - cout <= 1 for exactly the cycle in which a count step wraps; 0 on load or hold.
  - f <= new cnt value.
- **LOGIC (s=11)**
  - op=00 AND, 01 OR, 10 XOR, 11 NAND, all bitwise on a and b.
  - f <= result. cout <= 0.
- **Mode changes**
  - Take effect on the next edge. No pipeline flush is needed.
  - Switching back to SHIFT or COUNT resumes from the held sr/cnt.
- **Inputs**
  - All inputs are synchronous to clock. No X-propagation handling is required.

Decomposition:
- Package alu_pkg holds:
  - mode constants MODE_ADD=2'b00, MODE_SHIFT=2'b01, MODE_COUNT=2'b10, MODE_LOGIC=2'b11
  - sub-op constants SHL, SHR, ROL, ROR
  - sub-op constants LOG_AND, LOG_OR, LOG_XOR, LOG_NAND
  - direction constants UP, DOWN
- One natural sub-module: alu_counter_unit. Parametrised on WIDTH; owns cnt, load/enable priority, up/down and the wrap pulse.
- Adder, shifter, logic and the output mux stay in alu_seq.

Test Plan (WIDTH=8):
1. **Reset and ADD carry:** reset=1 for 1 cycle -> f=0x00, zero=1, cout=0. Then s=00, op=00, a=0xF0, b=0x20, L=1 -> next cycle f=0x11, cout=1, zero=0.
2. **Subtract borrow:** s=00, op=01, a=0x05, b=0x07, L=0 -> f=0xFE, cout=0 (borrow). Then a=0x07, b=0x05 -> f=0x02, cout=1.
3. **Counter load, wrap, priority:** s=10, L=1, En=1, a=0xFE -> f=0xFE.
   - L=0, En=1, op=00 for 2 cycles -> f=0xFF (cout=0), then f=0x00 with cout=1 for one cycle only.
   - op=01 -> f=0xFF, cout=1.
4. **Shift and hold:** after reset, s=01, op=00, En=1, a[0]=1 for 3 cycles -> f=0x01, 0x03, 0x07.
   - En=0 -> f stays 0x07.
   - op=11 (ROR), En=1 -> f=0x83.
5. **Mode interleave:** load cnt=0x10, run ADD for 3 cycles, return to s=10, En=1 -> f=0x11. sr is likewise unchanged by non-SHIFT cycles.
6. **Logic ops and mid-run reset:** a=0xCC, b=0xAA, s=11, op=00..11 -> f=0x88, 0xEE, 0x66, 0x77. Then assert reset while s=10, En=1 -> f=0, cnt=0, zero=1 on that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the registered ALU (alu_seq) and its counter.
//   mode_e      : the 2-bit mode select values
//   SHL..ROR    : shift sub-operations
//   LOG_*       : logic-unit sub-operations
//   UP/DOWN     : counter direction, taken from op[0]
package alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LOGIC = 2'b11
  } mode_e;

  localparam logic [1:0] SHL = 2'b00;
  localparam logic [1:0] SHR = 2'b01;
  localparam logic [1:0] ROL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  localparam logic [1:0] LOG_AND  = 2'b00;
  localparam logic [1:0] LOG_OR   = 2'b01;
  localparam logic [1:0] LOG_XOR  = 2'b10;
  localparam logic [1:0] LOG_NAND = 2'b11;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/alu_counter_unit.sv
// alu_counter_unit: loadable up/down modulo-2^WIDTH counter.
//   clock       : rising-edge clock
//   reset       : synchronous active-high reset, clears the count
//   sel_i       : counter mode selected; the count holds when low
//   load_i      : load strobe, has priority over enable
//   en_i        : count enable
//   dir_i       : UP or DOWN
//   load_val_i  : value loaded on load_i
//   cnt_next_o  : value the count takes at the coming edge (feeds f)
//   wrap_o      : high when the coming step wraps around
module alu_counter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sel_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (sel_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (en_i) begin
        if (dir_i == UP) begin
          cnt_d  = cnt_q + ONE;
          wrap_d = &cnt_q;
        end else begin
          cnt_d  = cnt_q - ONE;
          wrap_d = ~|cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;
  assign wrap_o     = wrap_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: fully registered four-mode ALU (add/sub, shift, count, logic).
//   clock : rising-edge clock      reset : synchronous active-high reset
//   a, b  : operands (a also counter load value, a[0] shift serial input)
//   L     : carry/borrow-in for ADD, load strobe for COUNT
//   En    : enable for SHIFT and COUNT
//   s     : mode select           op    : sub-operation
//   f     : registered result     cout  : registered carry / wrap pulse
//   zero  : registered, high when f == 0
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             L,
  input  logic             En,
  input  logic [1:0]       s,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  // Adder / subtractor: subtraction is a + ~b + ~L, so cout is "no borrow".
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum;

  assign b_eff   = op[0] ? ~b : b;
  assign cin_eff = op[0] ? ~L : L;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

  // Bitwise logic unit.
  logic [WIDTH-1:0] logic_res;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign logic_res[gi] = (op == LOG_AND) ?  (a[gi] & b[gi]) :
                             (op == LOG_OR)  ?  (a[gi] | b[gi]) :
                             (op == LOG_XOR) ?  (a[gi] ^ b[gi]) :
                                               ~(a[gi] & b[gi]);
    end
  endgenerate

  // Shift register: only moves when SHIFT is selected and enabled.
  always_comb begin
    sr_d = sr_q;
    if ((s == MODE_SHIFT) && En) begin
      case (op)
        SHL:     sr_d = {sr_q[WIDTH-2:0], a[0]};
        SHR:     sr_d = {a[0], sr_q[WIDTH-1:1]};
        ROL:     sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        default: sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
      endcase
    end
  end

  // Counter.
  logic [WIDTH-1:0] cnt_next;
  logic             cnt_wrap;

  alu_counter_unit #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .sel_i      (s == MODE_COUNT),
    .load_i     (L),
    .en_i       (En),
    .dir_i      (op[0]),
    .load_val_i (a),
    .cnt_next_o (cnt_next),
    .wrap_o     (cnt_wrap)
  );

  // Output mux.
  always_comb begin
    f_d    = '0;
    cout_d = 1'b0;
    case (s)
      MODE_ADD: begin
        f_d    = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
      end
      MODE_SHIFT: f_d = sr_d;
      MODE_COUNT: begin
        f_d    = cnt_next;
        cout_d = cnt_wrap;
      end
      default: f_d = logic_res;
    endcase
    zero_d = (f_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q   <= '0;
      f_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      f_q    <= f_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  assign f    = f_q;
  assign cout = cout_q;
  assign zero = zero_q;

endmodule
